// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and operand signedness helpers.
package alu_pkg;

  typedef enum logic [2:0] {
    MULDIV_MUL    = 3'd0,
    MULDIV_MULH   = 3'd1,
    MULDIV_MULHSU = 3'd2,
    MULDIV_MULHU  = 3'd3,
    MULDIV_DIV    = 3'd4,
    MULDIV_DIVU   = 3'd5,
    MULDIV_REM    = 3'd6,
    MULDIV_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_a_signed(muldiv_op_e op);
    return op inside {MULDIV_MULH, MULDIV_MULHSU, MULDIV_DIV, MULDIV_REM};
  endfunction

  function automatic logic op_b_signed(muldiv_op_e op);
    return op inside {MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration on the {acc, shreg} pair: shift-add for multiply (LSB-first),
// restoring trial-subtract for divide (MSB-first).
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] shreg_nxt
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum       = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
    shifted   = {acc, shreg[XLEN-1]};
    trial     = shifted - {1'b0, operand};
    acc_nxt   = acc;
    shreg_nxt = shreg;
    if (is_div) begin
      // The partial remainder stays below the divisor, so bit XLEN of trial is a clean borrow.
      if (!trial[XLEN]) begin
        acc_nxt   = trial[XLEN-1:0];
        shreg_nxt = {shreg[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt   = shifted[XLEN-1:0];
        shreg_nxt = {shreg[XLEN-2:0], 1'b0};
      end
    end else begin
      {acc_nxt, shreg_nxt} = {sum, shreg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit, one bit per cycle on operand magnitudes.
// Define MULDIV_FAST_MUL_EN to compute multiplies in a single combinational step.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  // Handshake: a request transfers on an edge where in_valid_i & in_ready_o & !kill_i;
  // a result transfers on an edge where out_valid_o & out_ready_i & !kill_i.
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_e      op_q;
  logic            neg_q;
  logic [XLEN-1:0] acc_q, shreg_q, b_q, result_q;

  muldiv_op_e      op_in;
  logic            accept, sa, sb, neg_in, last;
  logic            div_by_zero, ovf, fast_mul, bypass;
  logic [XLEN-1:0] abs_a, abs_b, bypass_res, fast_res, calc_res;
  logic [XLEN-1:0] acc_nxt, shreg_nxt, quot, rem;
  logic [2*XLEN-1:0] prod;

  assign op_in  = muldiv_op_e'(op_i);
  assign accept = in_valid_i && (state_q == S_IDLE) && !kill_i;
  assign last   = (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    sa          = op_a_signed(op_in) & a_i[XLEN-1];
    sb          = op_b_signed(op_in) & b_i[XLEN-1];
    abs_a       = sa ? -a_i : a_i;
    abs_b       = sb ? -b_i : b_i;
    neg_in      = (op_in[2] && op_in[1]) ? sa : (sa ^ sb);
    div_by_zero = op_in[2] && (b_i == '0);
    ovf         = (op_in == MULDIV_DIV || op_in == MULDIV_REM) &&
                  (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [XLEN:0]            fa, fb;
  logic signed [2*XLEN+1:0] fprod;
  always_comb begin
    fa    = {op_a_signed(op_in) & a_i[XLEN-1], a_i};
    fb    = {op_b_signed(op_in) & b_i[XLEN-1], b_i};
    fprod = $signed(fa) * $signed(fb);
  end
  assign fast_mul = !op_in[2];
  assign fast_res = (op_in == MULDIV_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  assign bypass = div_by_zero || ovf || fast_mul;

  always_comb begin
    if (div_by_zero)  bypass_res = op_in[1] ? a_i : '1;
    else if (ovf)     bypass_res = op_in[1] ? '0 : a_i;
    else              bypass_res = fast_res;
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div    (op_q[2]),
    .acc       (acc_q),
    .shreg     (shreg_q),
    .operand   (b_q),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  // Sign fix-up on the final iteration's output, folded into the result register write.
  always_comb begin
    prod = {acc_nxt, shreg_nxt};
    if (neg_q) prod = -prod;
    quot = neg_q ? -shreg_nxt : shreg_nxt;
    rem  = neg_q ? -acc_nxt : acc_nxt;
    case (op_q)
      MULDIV_MUL:                 calc_res = prod[XLEN-1:0];
      MULDIV_DIV, MULDIV_DIVU:    calc_res = quot;
      MULDIV_REM, MULDIV_REMU:    calc_res = rem;
      default:                    calc_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (in_valid_i) state_d = bypass ? S_DONE : S_CALC;
        S_CALC:  if (last) state_d = S_DONE;
        S_DONE:  if (out_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q    <= '0;
      op_q     <= MULDIV_MUL;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      shreg_q  <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (kill_i) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= op_in;
      neg_q   <= neg_in;
      acc_q   <= '0;
      shreg_q <= abs_a;
      b_q     <= abs_b;
      if (bypass) result_q <= bypass_res;
    end else if (state_q == S_CALC) begin
      acc_q   <= acc_nxt;
      shreg_q <= shreg_nxt;
      cnt_q   <= cnt_q + 1'b1;
      if (last) result_q <= calc_res;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign result_o    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: results, latency, hold, back-to-back, kill and reset,
// plus a 16-bit instance for the width regression.
module tb_alu_muldiv;

  localparam int XLEN = 32;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, kill, out_valid, out_ready, busy;
  logic [2:0]      op;
  logic [XLEN-1:0] a, b, result;

  logic            in_valid16, in_ready16, out_valid16, busy16;
  logic [2:0]      op16;
  logic [15:0]     a16, b16, result16;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .kill_i(kill), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .result_o(result), .busy_o(busy)
  );

  alu_muldiv #(.XLEN(16)) u_dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .op_i(op16), .a_i(a16), .b_i(b16), .kill_i(1'b0), .out_valid_o(out_valid16),
    .out_ready_i(1'b1), .result_o(result16), .busy_o(busy16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, measure latency in edges counting the accept edge, check and consume the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    op = o; a = x; b = y; in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, result, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = '0; b = '0;
    in_valid16 = 1'b0; op16 = 3'd0; a16 = '0; b16 = '0;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
    run_op("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, MUL_LAT);
    run_op("mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
    run_op("mulh_m3_5", 3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, MUL_LAT);

    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, XLEN + 1);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, XLEN + 1);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, XLEN + 1);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, XLEN + 1);
    run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, XLEN + 1);

    run_op("div_by0", 3'd4, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    run_op("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1);

    // Hold in DONE for 10 cycles with a competing request present.
    op = 3'd5; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("hold_latency", lat, XLEN + 1);
    held = result;
    check("hold_value", held, 32'd14);
    op = 3'd0; a = 32'd3; b = 32'd3;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_result", result, 32'd14);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    // Back-to-back: release and request on the same edge, nothing accepted there.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd0);
    check("b2b_out_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b_accept", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("b2b_latency", lat, MUL_LAT);
    check("b2b_result", result, 32'd9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Kill at CALC cycle 12.
    op = 3'd5; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("kill_pre_busy", {31'd0, busy}, 32'd1);
    kill = 1'b1; in_valid = 1'b1;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    check("kill_busy", {31'd0, busy}, 32'd0);
    check("kill_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < XLEN + 4; i++) begin
      tick();
      if (out_valid) check("kill_no_valid", {31'd0, out_valid}, 32'd0);
    end
    check("kill_quiet", {31'd0, out_valid}, 32'd0);

    // Kill beats in_valid in IDLE.
    kill = 1'b1; in_valid = 1'b1;
    tick();
    kill = 1'b0; in_valid = 1'b0;
    check("kill_idle_busy", {31'd0, busy}, 32'd0);

    // Reset mid-CALC.
    op = 3'd5; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstmid_result", result, 32'd0);
    rst_n = 1'b1;
    tick();
    run_op("post_rst_divu", 3'd5, 32'd1000, 32'd3, 32'd333, XLEN + 1);

    // 16-bit instance.
    op16 = 3'd5; a16 = 16'hFFFF; b16 = 16'd3; in_valid16 = 1'b1;
    check("x16_in_ready", {31'd0, in_ready16}, 32'd1);
    tick();
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 200) begin
      tick();
      lat++;
    end
    check("x16_latency", lat, 17);
    check("x16_divu", {16'd0, result16}, 32'h5555);
    tick();
    check("x16_idle", {31'd0, busy16}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
